operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter DATA_W, default 16: register data width.
REQ-002 Parameter ADDR_W, default 5: register address width; 32 addresses, register 0 reads as zero.
REQ-003 Clock and reset: reset reset, synchronous, active-high; clock clk.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 req_valid  in  1  decoded-instruction request present.
REQ-007 req_ready  out  1  request accepted on the current edge when both req_valid and req_ready are high.
REQ-008 req_rs_a, req_rs_b  in  ADDR_W each  source register addresses.
REQ-009 req_use_a, req_use_b  in  1 each  source operand needed.
REQ-010 req_wr  in  1  instruction writes a destination register.
REQ-011 req_rd  in  ADDR_W  destination register.
REQ-012 op_valid  out  1  operand bundle valid.
REQ-013 op_ready  in  1  consumer accepts the bundle.
REQ-014 op_a, op_b  out  DATA_W each  operands.
REQ-015 op_rd  out  ADDR_W  destination register passed through.
REQ-016 op_wr  out  1  req_wr passed through.
REQ-017 wb_valid  in  1  writeback present; always accepted.
REQ-018 wb_addr  in  ADDR_W  writeback register.
REQ-019 wb_data  in  DATA_W  writeback value.
REQ-020 rf_read_a, rf_read_b  out  1 each  register-file read enables.
REQ-021 rf_a_addr, rf_b_addr  out  ADDR_W each  register-file read addresses.
REQ-022 rf_a_out, rf_b_out  in  DATA_W each  register-file read data; registered, valid one cycle after the read enable; holds its value while the enable is low.
REQ-023 rf_write  out  1  register-file write enable.
REQ-024 rf_w_addr  out  ADDR_W  register-file write address.
REQ-025 rf_d_in  out  DATA_W  register-file write data.

Function
REQ-026 States: IDLE, WAIT_RF and HOLD.
REQ-027 Scoreboard: busy[31:1], one bit per register; register 0 is never busy.
REQ-028 Hazard when any of the following holds: (req_use_a and busy[req_rs_a]), (req_use_b and busy[req_rs_b]), or (req_wr and busy[req_rd]).
REQ-029 req_ready = (state==IDLE or (state==HOLD and op_ready)) and not hazard and not reset.
REQ-030 On acceptance, rf_read_a = req_use_a and rf_a_addr = req_rs_a combinationally in the same cycle; b likewise.
REQ-031 Outside acceptance, rf_read_a and rf_read_b are 0.
REQ-032 On acceptance, latch use_a, use_b, rs_a, rs_b, rd and wr, then go to WAIT_RF.
REQ-033 On acceptance with req_wr=1 and req_rd!=0, set busy[req_rd].
REQ-034 In WAIT_RF, op_a = rf_a_out if use_a=1 and rs_a!=0, else 0; op_b likewise.
REQ-035 In WAIT_RF, op_rd and op_wr are loaded from the latched request; then go to HOLD.
REQ-036 op_valid=1 exactly in HOLD; latency is accept edge to op_valid = 2 cycles.
REQ-037 In HOLD, op_* are held stable while op_ready=0.
REQ-038 In HOLD with op_ready=1: go to WAIT_RF if a new request is accepted on the same edge, else go to IDLE; peak throughput is one bundle per 2 cycles.
REQ-039 Writeback: rf_write = wb_valid and wb_addr!=0 and not reset.
REQ-040 Writeback: rf_w_addr = wb_addr and rf_d_in = wb_data, combinational pass-through.
REQ-041 A writeback with wb_addr!=0 clears busy[wb_addr] on the same edge.
REQ-042 If a set and a clear of the same busy bit occur on the same edge, the set wins.
REQ-043 A writeback to a non-busy register is still written; a same-cycle read of that register returns the pre-write value.
REQ-044 A request stalled by a hazard becomes acceptable the cycle after the clearing writeback; the read then returns the new value.

Reset
REQ-045 On reset: state=IDLE, busy cleared, op_valid=0, op_a=op_b=0, op_rd=0 and op_wr=0.
REQ-046 During reset, req_ready=0, rf_write=0 and rf_read_a=rf_read_b=0.
REQ-047 Reset mid-operation (WAIT_RF or HOLD) discards the in-flight bundle; no stale op_valid appears after reset.

Verification
REQ-048 Reset, then wb r3=0x1234; request rs_a=3, use_a=1, rs_b=0, use_b=1, wr=0 -> op_valid 2 cycles after accept, op_a=0x1234, op_b=0.
REQ-049 Request wr=1, rd=5, then a request reading r5 -> req_ready=0 until wb r5=0xBEEF; accepted the next cycle; op_a=0xBEEF.
REQ-050 op_ready held 0 for 4 cycles in HOLD -> op_valid stays 1 and op_a, op_b and op_rd remain unchanged.
REQ-051 Back-to-back: op_ready=1 with a hazard-free req_valid pending in HOLD -> same-edge accept; bundles are spaced 2 cycles apart.
REQ-052 wb to r0 with 0xFFFF -> rf_write=0; a later read of r0 yields op_a=0.
REQ-053 Reset asserted in WAIT_RF after a wr=1, rd=7 accept -> op_valid=0 and busy[7]=0, so a following read of r7 is accepted immediately.

Source files
------------

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : operand_fetch
//  Purpose  : Accepts decoded instructions, tracks pending destination
//             writes on a per-register busy scoreboard, stalls on RAW/WAW
//             hazards, reads both source operands from a registered
//             register file and presents them as a held operand bundle.
//             Writebacks pass straight through to the register file and
//             clear the matching busy bit.
//  Revision : 1.0  initial release
// ============================================================================
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  // decoded-instruction request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs_a,
  input  logic [ADDR_W-1:0] req_rs_b,
  input  logic              req_use_a,
  input  logic              req_use_b,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_rd,
  // operand bundle
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_rd,
  output logic              op_wr,
  // writeback
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  // register file
  output logic              rf_read_a,
  output logic              rf_read_b,
  output logic [ADDR_W-1:0] rf_a_addr,
  output logic [ADDR_W-1:0] rf_b_addr,
  input  logic [DATA_W-1:0] rf_a_out,
  input  logic [DATA_W-1:0] rf_b_out,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_d_in
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RF = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NREG-1:0]     busy_q, busy_d;
  logic                use_a_q, use_a_d;
  logic                use_b_q, use_b_d;
  logic [ADDR_W-1:0]   rs_a_q, rs_a_d;
  logic [ADDR_W-1:0]   rs_b_q, rs_b_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [ADDR_W-1:0]   op_rd_q, op_rd_d;
  logic                op_wr_q, op_wr_d;

  logic                hazard;
  logic                accept;

  // Hazard: a needed source or the destination still has a write in flight.
  always_comb begin
    hazard = (req_use_a && busy_q[req_rs_a]) ||
             (req_use_b && busy_q[req_rs_b]) ||
             (req_wr    && busy_q[req_rd]);
  end

  // Handshake, register-file read/write strobes and output pass-throughs.
  always_comb begin
    req_ready = ((state_q == IDLE) || ((state_q == HOLD) && op_ready)) &&
                !hazard && !reset;
    accept    = req_valid && req_ready;
    rf_read_a = accept && req_use_a;
    rf_read_b = accept && req_use_b;
    rf_a_addr = req_rs_a;
    rf_b_addr = req_rs_b;
    rf_write  = wb_valid && (wb_addr != '0) && !reset;
    rf_w_addr = wb_addr;
    rf_d_in   = wb_data;
    op_valid  = (state_q == HOLD);
    op_a      = op_a_q;
    op_b      = op_b_q;
    op_rd     = op_rd_q;
    op_wr     = op_wr_q;
  end

  // Scoreboard update: writeback clears first so a same-edge set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_write) begin
      busy_d[wb_addr] = 1'b0;
    end
    if (accept && req_wr && (req_rd != '0)) begin
      busy_d[req_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Next state, request latch and operand bundle capture.
  always_comb begin
    state_d = state_q;
    use_a_d = use_a_q;
    use_b_d = use_b_q;
    rs_a_d  = rs_a_q;
    rs_b_d  = rs_b_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    op_rd_d = op_rd_q;
    op_wr_d = op_wr_q;

    if (accept) begin
      use_a_d = req_use_a;
      use_b_d = req_use_b;
      rs_a_d  = req_rs_a;
      rs_b_d  = req_rs_b;
      rd_d    = req_rd;
      wr_d    = req_wr;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT_RF;
        end
      end
      WAIT_RF: begin
        // Register-file data arrives this cycle; register 0 and unused
        // operands are forced to zero regardless of what the RF returns.
        op_a_d  = (use_a_q && (rs_a_q != '0)) ? rf_a_out : '0;
        op_b_d  = (use_b_q && (rs_b_q != '0)) ? rf_b_out : '0;
        op_rd_d = rd_q;
        op_wr_d = wr_q;
        state_d = HOLD;
      end
      HOLD: begin
        if (op_ready) begin
          state_d = accept ? WAIT_RF : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, scoreboard and bundle registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= '0;
      use_a_q <= 1'b0;
      use_b_q <= 1'b0;
      rs_a_q  <= '0;
      rs_b_q  <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      op_rd_q <= '0;
      op_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      use_a_q <= use_a_d;
      use_b_q <= use_b_d;
      rs_a_q  <= rs_a_d;
      rs_b_q  <= rs_b_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      op_rd_q <= op_rd_d;
      op_wr_q <= op_wr_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_fetch
//  Purpose  : Directed self-checking bench for operand_fetch with a small
//             registered register-file model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_fetch;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              reset;
  logic              req_valid, req_ready;
  logic [ADDR_W-1:0] req_rs_a, req_rs_b, req_rd;
  logic              req_use_a, req_use_b, req_wr;
  logic              op_valid, op_ready, op_wr;
  logic [DATA_W-1:0] op_a, op_b;
  logic [ADDR_W-1:0] op_rd;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rf_read_a, rf_read_b, rf_write;
  logic [ADDR_W-1:0] rf_a_addr, rf_b_addr, rf_w_addr;
  logic [DATA_W-1:0] rf_a_out, rf_b_out, rf_d_in;

  logic              rf_clear;
  logic [DATA_W-1:0] regs [32];

  int n_vec;
  int n_err;

  operand_fetch #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs_a(req_rs_a), .req_rs_b(req_rs_b),
    .req_use_a(req_use_a), .req_use_b(req_use_b),
    .req_wr(req_wr), .req_rd(req_rd),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_wr(op_wr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_read_a(rf_read_a), .rf_read_b(rf_read_b),
    .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
    .rf_a_out(rf_a_out), .rf_b_out(rf_b_out),
    .rf_write(rf_write), .rf_w_addr(rf_w_addr), .rf_d_in(rf_d_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered register file: reads return the pre-write value on a
  // same-edge write. Register 0 holds a nonzero junk value on purpose.
  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 32; i++) regs[i] <= 16'hA500 + 16'(i);
      rf_a_out <= '0;
      rf_b_out <= '0;
    end else begin
      if (rf_write) regs[rf_w_addr] <= rf_d_in;
      if (rf_read_a) rf_a_out <= regs[rf_a_addr];
      if (rf_read_b) rf_b_out <= regs[rf_b_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [4:0] ra, input logic ua,
                     input logic [4:0] rb, input logic ub,
                     input logic w, input logic [4:0] rd);
    req_valid = v; req_rs_a = ra; req_use_a = ua;
    req_rs_b = rb; req_use_b = ub; req_wr = w; req_rd = rd;
  endtask

  task automatic wb(input logic v, input logic [4:0] a, input logic [15:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rf_clear = 1'b1;
    reset = 1'b1;
    op_ready = 1'b0;
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    wb(1'b0, 5'd0, 16'h0);
    tick();
    rf_clear = 1'b0;
    // Activity presented during reset must be masked.
    req(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0);
    wb(1'b1, 5'd3, 16'h5555);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rf_write",  32'(rf_write),  32'd0);
    check("rst_rf_read_a", 32'(rf_read_a), 32'd0);
    check("rst_rf_read_b", 32'(rf_read_b), 32'd0);
    tick();
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_op_a",     32'(op_a),     32'd0);
    check("rst_op_b",     32'(op_b),     32'd0);
    check("rst_op_rd",    32'(op_rd),    32'd0);
    check("rst_op_wr",    32'(op_wr),    32'd0);
    reset = 1'b0;
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    wb(1'b0, 5'd0, 16'h0);
    tick();

    // Basic fetch: wb r3, then read r3 and r0.
    wb(1'b1, 5'd3, 16'h1234);
    #1;
    check("wb_rf_write", 32'(rf_write),  32'd1);
    check("wb_w_addr",   32'(rf_w_addr), 32'd3);
    check("wb_d_in",     32'(rf_d_in),   32'h1234);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    req(1'b1, 5'd3, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0);
    #1;
    check("b1_ready",   32'(req_ready), 32'd1);
    check("b1_read_a",  32'(rf_read_a), 32'd1);
    check("b1_a_addr",  32'(rf_a_addr), 32'd3);
    check("b1_read_b",  32'(rf_read_b), 32'd1);
    tick();
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("b1_wait_valid", 32'(op_valid),  32'd0);
    check("b1_idle_read",  32'(rf_read_a), 32'd0);
    tick();
    check("b1_valid", 32'(op_valid), 32'd1);
    check("b1_op_a",  32'(op_a),     32'h1234);
    check("b1_op_b",  32'(op_b),     32'd0);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("b1_drained", 32'(op_valid), 32'd0);

    // RAW hazard on r5 until its writeback.
    req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5);
    #1;
    check("w5_ready", 32'(req_ready), 32'd1);
    tick();
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    check("w5_op_wr", 32'(op_wr), 32'd1);
    check("w5_op_rd", 32'(op_rd), 32'd5);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    req(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("haz_stall0", 32'(req_ready), 32'd0);
    tick();
    check("haz_stall1", 32'(req_ready), 32'd0);
    wb(1'b1, 5'd5, 16'hBEEF);
    #1;
    check("haz_stall_wb", 32'(req_ready), 32'd0);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    #1;
    check("haz_release", 32'(req_ready), 32'd1);
    tick();
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    check("haz_valid", 32'(op_valid), 32'd1);
    check("haz_op_a",  32'(op_a),     32'hBEEF);

    // Hold stable under backpressure with a request pending.
    req(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 1'b1, 5'd9);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_valid", 32'(op_valid),  32'd1);
      check("hold_op_a",  32'(op_a),      32'hBEEF);
      check("hold_op_b",  32'(op_b),      32'd0);
      check("hold_op_rd", 32'(op_rd),     32'd0);
      check("hold_ready", 32'(req_ready), 32'd0);
    end

    // Back-to-back bundles two cycles apart.
    op_ready = 1'b1;
    #1;
    check("b2b_ready0", 32'(req_ready), 32'd1);
    tick();
    req(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    op_ready = 1'b0;
    #1;
    check("b2b_gap_valid", 32'(op_valid),  32'd0);
    check("b2b_gap_ready", 32'(req_ready), 32'd0);
    tick();
    check("b2b_v1",    32'(op_valid), 32'd1);
    check("b2b_a1",    32'(op_a),     32'h1234);
    check("b2b_b1",    32'(op_b),     32'hBEEF);
    check("b2b_rd1",   32'(op_rd),    32'd9);
    check("b2b_wr1",   32'(op_wr),    32'd1);
    op_ready = 1'b1;
    #1;
    check("b2b_ready1", 32'(req_ready), 32'd1);
    tick();
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    op_ready = 1'b0;
    #1;
    check("b2b_gap2", 32'(op_valid), 32'd0);
    tick();
    check("b2b_v2",  32'(op_valid), 32'd1);
    check("b2b_a2",  32'(op_a),     32'hBEEF);
    check("b2b_b2",  32'(op_b),     32'd0);
    check("b2b_wr2", 32'(op_wr),    32'd0);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Clear r9, then set and clear r9 on the same edge: set wins.
    wb(1'b1, 5'd9, 16'h0909);
    tick();
    req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
    wb(1'b1, 5'd9, 16'h0A0A);
    #1;
    check("sw_ready", 32'(req_ready), 32'd1);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    req(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("sw_still_busy", 32'(req_ready), 32'd0);
    wb(1'b1, 5'd9, 16'h0B0B);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    #1;
    check("sw_release", 32'(req_ready), 32'd1);
    tick();
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    check("sw_op_a", 32'(op_a), 32'h0B0B);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Writeback to r0 is dropped; r0 always reads as zero.
    wb(1'b1, 5'd0, 16'hFFFF);
    #1;
    check("r0_rf_write", 32'(rf_write), 32'd0);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    req(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0);
    tick();
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    check("r0_op_a", 32'(op_a), 32'd0);
    check("r0_op_b", 32'(op_b), 32'd0);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Same-cycle write and read of a non-busy register returns old value.
    req(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    wb(1'b1, 5'd3, 16'h3333);
    #1;
    check("pw_ready", 32'(req_ready), 32'd1);
    tick();
    wb(1'b0, 5'd0, 16'h0);
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    check("pw_op_a", 32'(op_a), 32'h1234);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;

    // Reset in WAIT_RF discards the bundle and the busy bit for r7.
    req(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7);
    tick();
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_valid", 32'(op_valid), 32'd0);
    check("mr_op_wr", 32'(op_wr),    32'd0);
    tick();
    check("mr_no_stale", 32'(op_valid), 32'd0);
    req(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    #1;
    check("mr_r7_ready", 32'(req_ready), 32'd1);
    tick();
    req(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
    tick();
    check("mr_op_a", 32'(op_a), 32'hA507);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
